// File: rtl/multi_blinker_pkg.sv
// Shared encodings for the multi-channel blinker: channel modes, config
// register selects and the per-channel configuration record.
package multi_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    SEL_MODE  = 2'd0,
    SEL_HALF  = 2'd1,
    SEL_PHASE = 2'd2,
    SEL_RSVD  = 2'd3
  } sel_t;

  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    mode_t                mode;
    logic [DEF_CNT_W-1:0] halfPeriod;
    logic [DEF_CNT_W-1:0] phase;
  } ch_cfg_t;

  // Modes that own a running counter and are (re)loaded by arm/restart.
  function automatic logic isCountingMode(mode_t m);
    return (m == MODE_BLINK) || (m == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/multi_blinker_channel.sv
// One blink engine: config registers, phase counter, level and registered
// out/done. Config writes land before restart; arm/restart beat the tick.
module blink_channel
  import multi_blinker_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_restart,
  input  logic             i_we,
  input  logic [1:0]       i_sel,
  input  logic [CNT_W-1:0] i_data,
  output logic             o_out,
  output logic             o_done
);

  mode_t            r_mode;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_chCnt;
  logic             r_level;
  logic             r_doneEvt;

  mode_t            w_modeNext;
  logic [CNT_W-1:0] w_halfNext;
  logic [CNT_W-1:0] w_phaseNext;
  logic [CNT_W-1:0] w_hp;
  logic [CNT_W-1:0] w_load;
  logic             w_arm;
  logic             w_wrap;

  always_comb begin
    w_modeNext  = r_mode;
    w_halfNext  = r_half;
    w_phaseNext = r_phase;
    w_arm       = 1'b0;
    if (i_we) begin
      case (i_sel)
        SEL_MODE: begin
          w_modeNext = mode_t'(i_data[1:0]);
          w_arm      = isCountingMode(mode_t'(i_data[1:0]));
        end
        SEL_HALF:  w_halfNext  = i_data;
        SEL_PHASE: w_phaseNext = i_data;
        default: ;
      endcase
    end
    // A zero half-period behaves as one tick; phase beyond it loads as zero.
    w_hp   = (w_halfNext == '0) ? CNT_W'(1) : w_halfNext;
    w_load = (w_phaseNext < w_hp) ? w_phaseNext : '0;
    w_wrap = (r_chCnt >= (w_hp - 1'b1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= MODE_OFF;
      r_half    <= '0;
      r_phase   <= '0;
      r_chCnt   <= '0;
      r_level   <= 1'b0;
      r_doneEvt <= 1'b0;
      o_out     <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      r_mode    <= w_modeNext;
      r_half    <= w_halfNext;
      r_phase   <= w_phaseNext;
      r_doneEvt <= 1'b0;
      o_out     <= (r_mode == MODE_ON) || (r_mode == MODE_ONESHOT) ||
                   ((r_mode == MODE_BLINK) && r_level);
      o_done    <= r_doneEvt;
      if (w_arm || (i_restart && isCountingMode(w_modeNext))) begin
        r_chCnt <= w_load;
        r_level <= 1'b0;
      end else if (i_tick && isCountingMode(w_modeNext)) begin
        if (w_wrap) begin
          r_chCnt <= '0;
          if (w_modeNext == MODE_BLINK) begin
            r_level <= ~r_level;
          end else begin
            r_mode    <= MODE_OFF;
            r_doneEvt <= 1'b1;
          end
        end else begin
          r_chCnt <= r_chCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_blinker.sv
// Multi-channel blinker top: shared tick prescaler, config write decode and
// one blink_channel engine per channel.
module multi_blinker
  import multi_blinker_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PRESCALE_W = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [PRESCALE_W-1:0]                         prescale,
  input  logic                                          cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [1:0]                                    cfg_sel,
  input  logic [CNT_W-1:0]                              cfg_data,
  input  logic                                          sync_restart,
  output logic                                          tick,
  output logic [CHANNELS-1:0]                           blink_out,
  output logic [CHANNELS-1:0]                           done
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PRESCALE_W-1:0] r_preCnt;
  logic [CHANNELS-1:0]   w_chanWe;

  // Using >= lets a shrinking prescale wrap immediately instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_preCnt <= '0;
      tick     <= 1'b0;
    end else if (r_preCnt >= prescale) begin
      r_preCnt <= '0;
      tick     <= 1'b1;
    end else begin
      r_preCnt <= r_preCnt + 1'b1;
      tick     <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_chanWe[g] = cfg_we && (cfg_chan == CHAN_W'(g));

    blink_channel #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_tick   (tick),
      .i_restart(sync_restart),
      .i_we     (w_chanWe[g]),
      .i_sel    (cfg_sel),
      .i_data   (cfg_data),
      .o_out    (blink_out[g]),
      .o_done   (done[g])
    );
  end

endmodule

// File: tb/tb_multi_blinker.sv
// Directed, table-driven bench for multi_blinker with hand-computed
// expectations for blink timing, restart, one-shot and reset behaviour.
module tb_multi_blinker;
  import multi_blinker_pkg::*;

  localparam logic [15:0] D_OFF     = 16'd0;
  localparam logic [15:0] D_ON      = 16'd1;
  localparam logic [15:0] D_BLINK   = 16'd2;
  localparam logic [15:0] D_ONESHOT = 16'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  prescale;
  logic        cfg_we;
  logic [1:0]  cfg_chan;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        sync_restart;
  logic        tick;
  logic [3:0]  blink_out;
  logic [3:0]  done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [1:0]  chan;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  expOut;
    logic        expTick;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  multi_blinker #(
    .CHANNELS  (4),
    .CNT_W     (16),
    .PRESCALE_W(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prescale    (prescale),
    .cfg_we      (cfg_we),
    .cfg_chan    (cfg_chan),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .sync_restart(sync_restart),
    .tick        (tick),
    .blink_out   (blink_out),
    .done        (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] chan, input logic [1:0] sel,
                               input logic [15:0] data, input logic restart);
    cfg_we       = we;
    cfg_chan     = chan;
    cfg_sel      = sel;
    cfg_data     = data;
    sync_restart = restart;
    step();
    cfg_we       = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic writeCfg(input logic [1:0] chan, input logic [1:0] sel, input logic [15:0] data);
    applyStimulus(1'b1, chan, sel, data, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b0);
  endtask

  task automatic waitChange(input int ch, input int limit, output int n);
    logic prev;
    prev = blink_out[ch];
    n = 0;
    while (blink_out[ch] === prev && n < limit) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    int highs;
    logic [11:0] exp0;
    logic [11:0] exp2;

    rst_n = 1'b0;
    prescale = 8'd0;
    cfg_we = 1'b0;
    cfg_chan = 2'd0;
    cfg_sel = 2'd0;
    cfg_data = 16'd0;
    sync_restart = 1'b0;

    step();
    step();
    checkOutput("reset_out", 32'(blink_out), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_tick", 32'(tick), 32'h0);
    rst_n = 1'b1;

    // ch0 hp=3 blink with tick every cycle: arm at edge 2, out lags level by one edge
    vecs[0]  = '{1'b1, 2'd0, SEL_HALF, 16'd3,  4'b0000, 1'b1};
    vecs[1]  = '{1'b1, 2'd0, SEL_MODE, D_BLINK, 4'b0000, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0000, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0000, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0000, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0001, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0001, 1'b1};
    vecs[7]  = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0001, 1'b1};
    vecs[8]  = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0000, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0000, 1'b1};
    vecs[10] = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0000, 1'b1};
    vecs[11] = '{1'b0, 2'd0, SEL_MODE, 16'd0,  4'b0001, 1'b1};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].we, vecs[i].chan, vecs[i].sel, vecs[i].data, 1'b0);
      checkOutput($sformatf("t1_out_%0d", i), 32'(blink_out), 32'(vecs[i].expOut));
      checkOutput($sformatf("t1_tick_%0d", i), 32'(tick), 32'(vecs[i].expTick));
    end

    // prescale=4: tick every 5 clocks, ch1 hp=2 toggles every 10 clocks
    writeCfg(2'd0, SEL_MODE, D_OFF);
    prescale = 8'd4;
    writeCfg(2'd1, SEL_HALF, 16'd2);
    writeCfg(2'd1, SEL_MODE, D_BLINK);
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      idle();
      n++;
    end
    idle();
    n = 1;
    while (tick !== 1'b1 && n < 20) begin
      idle();
      n++;
    end
    checkOutput("t2_tick_period", 32'(n), 32'd5);
    waitChange(1, 100, n);
    waitChange(1, 100, n);
    checkOutput("t2_half_a", 32'(n), 32'd10);
    waitChange(1, 100, n);
    checkOutput("t2_half_b", 32'(n), 32'd10);

    // ch0/ch2 hp=4, ch2 phase=2, restart: ch2 leads ch0 by 2 ticks
    prescale = 8'd0;
    writeCfg(2'd1, SEL_MODE, D_OFF);
    writeCfg(2'd0, SEL_HALF, 16'd4);
    writeCfg(2'd2, SEL_HALF, 16'd4);
    writeCfg(2'd2, SEL_PHASE, 16'd2);
    writeCfg(2'd0, SEL_MODE, D_BLINK);
    writeCfg(2'd2, SEL_MODE, D_BLINK);
    applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b1);
    exp0 = 12'b000011110000;
    exp2 = 12'b110000111100;
    for (int m = 0; m < 12; m++) begin
      idle();
      checkOutput($sformatf("t3_ch2ch0_%0d", m + 1), 32'({blink_out[2], blink_out[0]}),
                  32'({exp2[m], exp0[m]}));
    end

    // ch3 hp=5 one-shot: high 5 cycles, done as it falls, then stays off
    writeCfg(2'd0, SEL_MODE, D_OFF);
    writeCfg(2'd2, SEL_MODE, D_OFF);
    writeCfg(2'd3, SEL_HALF, 16'd5);
    writeCfg(2'd3, SEL_MODE, D_ONESHOT);
    for (int m = 1; m <= 8; m++) begin
      idle();
      checkOutput($sformatf("t4_out_%0d", m), 32'(blink_out), (m <= 5) ? 32'h8 : 32'h0);
      checkOutput($sformatf("t4_done_%0d", m), 32'(done), (m == 6) ? 32'h8 : 32'h0);
    end
    highs = 0;
    for (int m = 0; m < 10; m++) begin
      idle();
      if (blink_out[3] !== 1'b0 || done[3] !== 1'b0) highs++;
    end
    checkOutput("t4_stays_off", 32'(highs), 32'd0);

    // hp=0 behaves as 1, phase write lands before the same-cycle restart
    writeCfg(2'd0, SEL_HALF, 16'd0);
    writeCfg(2'd0, SEL_MODE, D_BLINK);
    applyStimulus(1'b1, 2'd0, SEL_PHASE, 16'd1, 1'b1);
    for (int m = 1; m <= 4; m++) begin
      idle();
      checkOutput($sformatf("t5_ch0_%0d", m), 32'(blink_out[0]), 32'((m % 2) == 0));
    end
    writeCfg(2'd2, SEL_MODE, D_BLINK);
    applyStimulus(1'b1, 2'd2, SEL_PHASE, 16'd3, 1'b1);
    idle();
    checkOutput("t5_ch2_newphase_1", 32'(blink_out[2]), 32'h0);
    idle();
    checkOutput("t5_ch2_newphase_2", 32'(blink_out[2]), 32'h1);
    writeCfg(2'd1, SEL_MODE, D_ON);
    idle();
    checkOutput("t5_ch1_on", 32'(blink_out[1]), 32'h1);
    writeCfg(2'd1, SEL_RSVD, 16'h0000);
    idle();
    checkOutput("t5_rsvd_a", 32'(blink_out[1]), 32'h1);
    idle();
    checkOutput("t5_rsvd_b", 32'(blink_out[1]), 32'h1);

    // reset while ch3 one-shot is about to report done and others are active
    writeCfg(2'd3, SEL_HALF, 16'd2);
    writeCfg(2'd3, SEL_MODE, D_ONESHOT);
    idle();
    idle();
    checkOutput("t6_mid_oneshot", 32'(blink_out[3]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_out", 32'(blink_out), 32'h0);
    checkOutput("t6_async_done", 32'(done), 32'h0);
    checkOutput("t6_async_tick", 32'(tick), 32'h0);
    step();
    checkOutput("t6_held_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    highs = 0;
    for (int m = 0; m < 10; m++) begin
      idle();
      if (blink_out !== 4'h0 || done !== 4'h0) highs++;
    end
    checkOutput("t6_after_release", 32'(highs), 32'd0);
    checkOutput("t6_tick_resumes", 32'(tick), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
